// File: rtl/nuc_coef_sched_if.sv
// Burst-read command channel from the coefficient scheduler to the memory read mover.
interface nuc_coef_sched_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] addr;
  logic [22:0] btt;
  logic        sel;

  modport master (output tvalid, output addr, output btt, output sel, input tready);
  modport slave  (input tvalid, input addr, input btt, input sel, output tready);
endinterface

// File: rtl/nuc_coef_sched.sv
// Frame-synchronous scheduler issuing interleaved gain/offset burst reads for the NUC path,
// throttled by a burst-pair credit counter.
module nuc_coef_sched #(
  parameter int FRAME_WORDS     = 40960,
  parameter int BURST_WORDS     = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     axis_aclk,
  input  logic                     axis_areset,
  input  logic                     enable,
  input  logic [31:0]              gain_base,
  input  logic [31:0]              ofst_base,
  input  logic                     frame_start,
  nuc_coef_sched_if.master         m_cmd,
  input  logic                     pair_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int              NB          = (FRAME_WORDS + BURST_WORDS - 1) / BURST_WORDS;
  localparam int              LAST_WORDS  = FRAME_WORDS - (NB - 1) * BURST_WORDS;
  localparam int              KW          = $clog2(NB + 1);
  localparam logic [KW-1:0]   K_LAST      = KW'(NB - 1);
  localparam logic [31:0]     BURST_BYTES = 32'(BURST_WORDS * 4);
  localparam logic [22:0]     FULL_BTT    = 23'(BURST_WORDS * 4);
  localparam logic [22:0]     LAST_BTT    = 23'(LAST_WORDS * 4);
  localparam logic [3:0]      MAX_OUT     = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE_GAIN, ISSUE_OFST, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   off_q, off_d;
  logic [31:0]   gain_base_q, gain_base_d;
  logic [31:0]   ofst_base_q, ofst_base_d;
  logic [3:0]    out_q, out_d;
  logic          tvalid_q, tvalid_d;
  logic [31:0]   addr_q, addr_d;
  logic [22:0]   btt_q, btt_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          hs, cred_inc, cred_dec;

  always_comb begin
    hs       = tvalid_q && m_cmd.tready;
    cred_inc = hs && (state_q == ISSUE_OFST);
    cred_dec = pair_done && (out_q != 4'd0);

    out_d = out_q;
    if (cred_inc && !cred_dec)
      out_d = out_q + 4'd1;
    else if (!cred_inc && cred_dec)
      out_d = out_q - 4'd1;

    state_d      = state_q;
    k_d          = k_q;
    off_d        = off_q;
    gain_base_d  = gain_base_q;
    ofst_base_d  = ofst_base_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    addr_d       = addr_q;
    btt_d        = btt_q;
    sel_d        = sel_q;

    case (state_q)
      IDLE: begin
        // The cycle carrying frame_done already counts as busy for new starts.
        if (frame_start && enable && !frame_done_q) begin
          gain_base_d = gain_base;
          ofst_base_d = ofst_base;
          k_d         = '0;
          off_d       = '0;
          busy_d      = 1'b1;
          state_d     = ISSUE_GAIN;
        end
      end
      ISSUE_GAIN: begin
        if (hs)
          state_d = ISSUE_OFST;
      end
      ISSUE_OFST: begin
        if (hs) begin
          k_d     = k_q + KW'(1);
          off_d   = off_q + BURST_BYTES;
          state_d = (k_q == K_LAST) ? WAIT_DONE : ISSUE_GAIN;
        end
      end
      WAIT_DONE: begin
        if (out_q == 4'd0) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = frame_start && ((state_q != IDLE) || frame_done_q);

    // Command outputs are precomputed for the next state so they leave a register.
    tvalid_d = (state_d == ISSUE_OFST) || ((state_d == ISSUE_GAIN) && (out_d < MAX_OUT));
    if ((state_d == ISSUE_GAIN) || (state_d == ISSUE_OFST)) begin
      sel_d  = (state_d == ISSUE_OFST);
      addr_d = ((state_d == ISSUE_OFST) ? ofst_base_d : gain_base_d) + off_d;
      btt_d  = (k_d == K_LAST) ? LAST_BTT : FULL_BTT;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      off_q        <= '0;
      gain_base_q  <= '0;
      ofst_base_q  <= '0;
      out_q        <= '0;
      tvalid_q     <= 1'b0;
      addr_q       <= '0;
      btt_q        <= '0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      off_q        <= off_d;
      gain_base_q  <= gain_base_d;
      ofst_base_q  <= ofst_base_d;
      out_q        <= out_d;
      tvalid_q     <= tvalid_d;
      addr_q       <= addr_d;
      btt_q        <= btt_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_cmd.tvalid = tvalid_q;
  assign m_cmd.addr   = addr_q;
  assign m_cmd.btt    = btt_q;
  assign m_cmd.sel    = sel_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_nuc_coef_sched.sv
// Bench for nuc_coef_sched: directed corner sequences plus randomized frames checked
// against a per-frame command list and a burst-pair credit count.
module tb_nuc_coef_sched;

  localparam int FW = 1000;
  localparam int BW = 256;
  localparam int MO = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [22:0] btt;
    logic        sel;
  } cmd_t;

  typedef struct {
    logic [31:0] addr;
    logic [22:0] btt;
    logic        sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] gain_base, ofst_base;
  logic        frame_start;
  logic        pair_done;
  logic        busy, frame_done, overrun;

  nuc_coef_sched_if cmd_if ();

  nuc_coef_sched #(
    .FRAME_WORDS    (FW),
    .BURST_WORDS    (BW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .axis_aclk  (clk),
    .axis_areset(rst),
    .enable     (enable),
    .gain_base  (gain_base),
    .ofst_base  (ofst_base),
    .frame_start(frame_start),
    .m_cmd      (cmd_if.master),
    .pair_done  (pair_done),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  cmd_t exp_q[$];
  cmd_t cap_q[$];
  int   mo = 0;
  int   hs_ofst = 0;
  int   pd_sent = 0;
  int   n_done = 0;
  int   n_ovr = 0;
  bit   auto_rdy = 0;
  bit   auto_pd = 0;
  int   rdy_pct = 100;
  bit   pv_vld = 0;
  bit   pv_rdy = 0;
  cmd_t pv_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected command list for one accepted frame, straight from the burst rules.
  task automatic push_frame(input logic [31:0] g, input logic [31:0] o);
    for (int k = 0; k * BW < FW; k++) begin
      int          w;
      logic [31:0] off;
      w   = (FW - k * BW < BW) ? (FW - k * BW) : BW;
      off = 32'(4 * k * BW);
      exp_q.push_back('{addr: g + off, btt: 23'(w * 4), sel: 1'b0});
      exp_q.push_back('{addr: o + off, btt: 23'(w * 4), sel: 1'b1});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mo      = 0;
    pd_sent = hs_ofst;
    pv_vld  = 0;
  endtask

  task automatic sample();
    cmd_t c;
    bit   hs;
    if (rst) begin
      pv_vld = 0;
      return;
    end
    c = '{addr: cmd_if.addr, btt: cmd_if.btt, sel: cmd_if.sel};
    if (pv_vld && !pv_rdy)
      chk("hold", {cmd_if.tvalid, c}, {1'b1, pv_cmd});
    hs = cmd_if.tvalid && cmd_if.tready;
    if (hs) begin
      cap_q.push_back(c);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL cmd_unexpected: got addr 0x%0h btt %0d sel %0d, required none", c.addr, c.btt, c.sel);
      end else begin
        chk("cmd", c, exp_q.pop_front());
      end
      if (!c.sel) chk("credit", 64'(mo < MO), 1);
      else hs_ofst++;
    end
    if (frame_done) begin
      n_done++;
      chk("done_early", 64'((exp_q.size() == 0) && (mo == 0)), 1);
    end
    if (overrun) n_ovr++;
    if (hs && c.sel && !(pair_done && mo > 0)) mo++;
    else if (!(hs && c.sel) && pair_done && mo > 0) mo--;
    if (pair_done && (mo > 0 || (hs && c.sel))) pd_sent++;
    pv_vld = cmd_if.tvalid;
    pv_rdy = cmd_if.tready;
    pv_cmd = c;
  endtask

  task automatic cycle();
    if (auto_rdy) cmd_if.tready = ($urandom_range(99) < rdy_pct);
    if (auto_pd) pair_done = ((hs_ofst - pd_sent) > 0) && ($urandom_range(3) == 0);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] g, input logic [31:0] o);
    push_frame(g, o);
    gain_base   = g;
    ofst_base   = o;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int i;
    start = n_done;
    i = 0;
    while (n_done == start && i < budget) begin
      cycle();
      i++;
    end
    chk("frame_done_seen", 64'(n_done > start), 1);
    chk("all_cmds_issued", exp_q.size(), 0);
    auto_pd   = 0;
    pair_done = 1'b0;
  endtask

  vec_t tab[8];
  int   ovr0;

  initial begin
    tab[0] = '{32'h1000_0000, 23'd1024, 1'b0};
    tab[1] = '{32'h2000_0000, 23'd1024, 1'b1};
    tab[2] = '{32'h1000_0400, 23'd1024, 1'b0};
    tab[3] = '{32'h2000_0400, 23'd1024, 1'b1};
    tab[4] = '{32'h1000_0800, 23'd1024, 1'b0};
    tab[5] = '{32'h2000_0800, 23'd1024, 1'b1};
    tab[6] = '{32'h1000_0C00, 23'd928,  1'b0};
    tab[7] = '{32'h2000_0C00, 23'd928,  1'b1};

    rst = 1'b1; enable = 1'b1; gain_base = '0; ofst_base = '0;
    frame_start = 1'b0; pair_done = 1'b0; cmd_if.tready = 1'b0;
    repeat (2) cycle();
    chk("rst_tvalid", cmd_if.tvalid, 0);
    chk("rst_addr", cmd_if.addr, 0);
    chk("rst_btt", cmd_if.btt, 0);
    chk("rst_sel", cmd_if.sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    cycle();

    // Partial last burst, full-rate acceptance.
    cap_q.delete();
    cmd_if.tready = 1'b1;
    auto_pd = 1;
    start_frame(32'h1000_0000, 32'h2000_0000);
    chk("start_busy", busy, 1);
    chk("start_vld", cmd_if.tvalid, 1);
    chk("start_addr", cmd_if.addr, 32'h1000_0000);
    wait_done(200);
    chk("tab_count", cap_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < cap_q.size())
        chk($sformatf("tab%0d", i), cap_q[i], {tab[i].addr, tab[i].btt, tab[i].sel});
    repeat (3) cycle();

    // pair_done at zero credit, then credit stall and exact frame_done timing.
    pair_done = 1'b1;
    cycle();
    pair_done = 1'b0;
    cap_q.delete();
    start_frame(32'h3000_0000, 32'h4000_0000);
    repeat (15) cycle();
    chk("stall_cmds", cap_q.size(), 4);
    chk("stall_vld", cmd_if.tvalid, 0);
    pair_done = 1'b1;
    cycle();
    pair_done = 1'b0;
    chk("release_vld", cmd_if.tvalid, 1);
    chk("release_sel", cmd_if.sel, 0);
    chk("release_addr", cmd_if.addr, 32'h3000_0800);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      pair_done = !cmd_if.tvalid && ((hs_ofst - pd_sent) > 0);
      cycle();
    end
    pair_done = 1'b0;
    chk("drain_out", mo, 2);
    pair_done = 1'b1;
    cycle();
    pair_done = 1'b0;
    cycle();
    chk("wait_busy", busy, 1);
    pair_done = 1'b1;
    cycle();
    pair_done = 1'b0;
    chk("done_lag", frame_done, 0);
    chk("busy_lag", busy, 1);
    cycle();
    chk("done_pulse", frame_done, 1);
    chk("busy_fall", busy, 0);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("ovr_at_done", overrun, 1);
    chk("ovr_no_start", cmd_if.tvalid, 0);
    chk("ovr_idle", busy, 0);
    cycle();
    chk("ovr_pulse_end", overrun, 0);
    chk("done_once", frame_done, 0);

    // Backpressure on an offset command.
    cmd_if.tready = 1'b0;
    start_frame(32'h5000_0000, 32'h6000_0000);
    cmd_if.tready = 1'b1;
    cycle();
    cmd_if.tready = 1'b0;
    chk("bp_sel", cmd_if.sel, 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_stable", {cmd_if.tvalid, cmd_if.addr, cmd_if.btt, cmd_if.sel},
          {1'b1, 32'h6000_0000, 23'd1024, 1'b1});
    end
    cmd_if.tready = 1'b1;
    cycle();
    chk("bp_done", hs_ofst > 0 && exp_q.size() == 6, 1);
    auto_pd = 1;
    wait_done(200);

    // Overrun mid-frame with enable dropped; the frame must finish unchanged.
    ovr0 = n_ovr;
    auto_rdy = 1; rdy_pct = 70; auto_pd = 1;
    start_frame(32'h7000_0000, 32'h7800_0000);
    enable = 1'b0;
    repeat (3) cycle();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("ovr_mid", overrun, 1);
    cycle();
    chk("ovr_mid_end", overrun, 0);
    wait_done(300);
    chk("ovr_count", n_ovr - ovr0, 1);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    repeat (5) cycle();
    chk("dis_vld", cmd_if.tvalid, 0);
    chk("dis_busy", busy, 0);
    chk("dis_ovr", n_ovr - ovr0, 1);
    enable = 1'b1;
    auto_rdy = 0;

    // Offset acceptance coincident with pair_done at MO-1 outstanding.
    cmd_if.tready = 1'b0;
    start_frame(32'h0800_0000, 32'h0900_0000);
    cmd_if.tready = 1'b1;
    repeat (3) cycle();
    chk("sim_ofst", {cmd_if.tvalid, cmd_if.sel}, 2'b11);
    pair_done = 1'b1;
    cycle();
    pair_done = 1'b0;
    chk("sim_next_gain", {cmd_if.tvalid, cmd_if.sel}, 2'b10);
    repeat (2) cycle();
    chk("sim_count", cmd_if.tvalid, 0);
    auto_pd = 1;
    wait_done(200);

    // Reset between gain and offset handshakes.
    cmd_if.tready = 1'b0;
    start_frame(32'hA000_0000, 32'hB000_0000);
    cmd_if.tready = 1'b1;
    cycle();
    cmd_if.tready = 1'b0;
    chk("pre_rst_sel", cmd_if.sel, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {cmd_if.tvalid, cmd_if.addr, cmd_if.btt, cmd_if.sel, busy, frame_done, overrun}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    cap_q.delete();
    auto_rdy = 1; rdy_pct = 60; auto_pd = 1;
    start_frame(32'hC000_0000, 32'hD000_0000);
    wait_done(300);
    if (cap_q.size() > 0) chk("rst_restart", cap_q[0], {32'hC000_0000, 23'd1024, 1'b0});
    else chk("rst_restart_count", cap_q.size(), 8);

    // Randomized frames, first one wrapping the address space.
    for (int f = 0; f < 5; f++) begin
      logic [31:0] g, o;
      g = (f == 0) ? 32'hFFFF_FE00 : $urandom;
      o = $urandom;
      rdy_pct = 30 + $urandom_range(70);
      auto_rdy = 1;
      auto_pd = 1;
      start_frame(g, o);
      wait_done(600);
      repeat ($urandom_range(4)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nuc_coef_sched.md
# nuc_coef_sched

Frame-synchronous command scheduler for the NUC coefficient path. At each raw-frame start it issues interleaved burst-read commands, gain burst k then offset burst k, to the memory read mover that feeds the gain and offset coefficient streams of the NUC datapath. It limits how many burst pairs are in flight with a credit counter, so the coefficient FIFOs cannot overflow. It reports frame completion and start-of-frame overruns.

## Interface
- `FRAME_WORDS`, default 40960: 32-bit coefficient words per table per frame (two pixels per word). Must be ≥ 1.
- `BURST_WORDS`, default 256: words per read burst. Must be ≥ 1.
- `MAX_OUTSTANDING`, default 4: maximum burst pairs in flight. Range 1..15.
- `axis_aclk`, in, 1: the single clock. All logic is rising-edge.
- `axis_areset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: when low, frame starts are ignored while IDLE.
- `gain_base`, in, 32: byte base address of the gain table. Sampled on the accepted frame start.
- `ofst_base`, in, 32: byte base address of the offset table. Sampled on the accepted frame start.
- `frame_start`, in, 1: single-cycle pulse on the first raw pixel handshake of a frame (tuser & tvalid & tready).
- `m_cmd_tvalid`, out, 1: command valid.
- `m_cmd_tready`, in, 1: command accepted by the mover.
- `m_cmd_addr`, out, 32: burst byte address.
- `m_cmd_btt`, out, 23: burst length in bytes (words × 4).
- `m_cmd_sel`, out, 1: 0 = gain, 1 = offset.
- `pair_done`, in, 1: single-cycle pulse when the consumer has drained one gain+offset burst pair.
- `busy`, out, 1: high from the accepted frame start until `frame_done`.
- `frame_done`, out, 1: single-cycle pulse when every pair of the frame has been drained.
- `overrun`, out, 1: single-cycle pulse on a `frame_start` received while busy.

## Operation
- NB = ceil(FRAME_WORDS / BURST_WORDS) burst pairs per frame.
- Burst k (0-based) covers min(BURST_WORDS, FRAME_WORDS − k·BURST_WORDS) words.
- The address of burst k is base + 4·k·BURST_WORDS, computed modulo 2^32 (wraps silently).
- `m_cmd_btt` = words·4, zero-extended to 23 bits.
- State IDLE:
  - `frame_start` && `enable` → latch both bases, clear the burst index, set `busy`, go to ISSUE_GAIN.
  - `frame_start` && !`enable` → ignored, no overrun.
- State ISSUE_GAIN:
  - If outstanding < MAX_OUTSTANDING, present the gain command.
  - On handshake, go to ISSUE_OFST.
  - If credits are exhausted, `m_cmd_tvalid` stays low and the state holds.
- State ISSUE_OFST:
  - Present the offset command for the same k.
  - On handshake, outstanding +1 and k +1.
  - Then go to WAIT_DONE if k was NB−1, else to ISSUE_GAIN.
- State WAIT_DONE: when outstanding reaches 0, pulse `frame_done`, clear `busy`, go to IDLE.
- Credit counter:
  - Increments on offset-command acceptance and decrements on `pair_done`.
  - Both in the same cycle → unchanged.
  - `pair_done` with outstanding = 0 is ignored (saturates at 0).
- `overrun`:
  - Pulses for `frame_start` in any non-IDLE state.
  - The current frame continues unaffected and the new start is discarded.
  - A `frame_start` arriving in the same cycle as the `frame_done` pulse is an overrun.
- `enable` deasserted mid-frame does not abort the frame.
- Reset (any time) clears all state at once:
  - State → IDLE; outstanding, k and latched bases → 0.
  - All outputs at their reset values. Any half-issued pair is dropped.
- Reset values: `m_cmd_tvalid` 0, `m_cmd_addr` 0, `m_cmd_btt` 0, `m_cmd_sel` 0, `busy` 0, `frame_done` 0, `overrun` 0.

## Timing
- All outputs are registered.
- `frame_start` at cycle t, accepted in IDLE → `busy` and the first gain `m_cmd_tvalid` at t+1, credits permitting.
- Handshake occurs on a rising edge with `m_cmd_tvalid` && `m_cmd_tready`.
- While valid and not ready, `m_cmd_addr`, `m_cmd_btt` and `m_cmd_sel` hold stable. Valid never drops without a handshake, except on reset.
- Gain handshake at cycle c → offset command valid at c+1. Offset handshake at c → next gain valid at c+1 if a credit remains. Sustained rate: 1 command/cycle.
- Credit release: `pair_done` at cycle c unblocks ISSUE_GAIN with valid at c+1.
- `frame_done` asserts the cycle after outstanding becomes 0 in WAIT_DONE, and `busy` falls in that same cycle.
- `overrun` asserts the cycle after the offending `frame_start`.

## Test plan
- Partial last burst. FRAME_WORDS=1000, BURST_WORDS=256, gain_base=0x1000_0000, ofst_base=0x2000_0000, tready=1, `pair_done` returned promptly → 8 commands in order:
  - 0x1000_0000/1024, 0x2000_0000/1024
  - 0x1000_0400/1024, 0x2000_0400/1024
  - 0x1000_0800/1024, 0x2000_0800/1024
  - 0x1000_0C00/928, 0x2000_0C00/928 (sel 0,1 alternating)
  - then a `frame_done` pulse.
- Credit stall. MAX_OUTSTANDING=2, no `pair_done` → exactly 4 commands, then `m_cmd_tvalid` stays low. One `pair_done` → the next gain command is valid on the following cycle.
- Backpressure. Hold `m_cmd_tready` low for 10 cycles on the offset command → valid, addr, btt and sel all stable for those cycles; the command completes after tready rises.
- Overrun and enable. `frame_start` while busy → one `overrun` pulse and the command sequence is unchanged. `frame_start` with enable=0 in IDLE → no command, no overrun.
- Simultaneous events. At outstanding = MAX_OUTSTANDING−1, offset acceptance coincides with `pair_done` → count unchanged and the next gain is issued immediately. `pair_done` at count 0 → count stays 0.
- Reset mid-frame. Assert `axis_areset` between the gain and offset handshakes → all outputs return to reset values immediately. A new `frame_start` restarts at k=0 with freshly latched bases.
